// File: rtl/audio_dac_serializer.sv
// Mono left-justified audio serializer: converts a sign/magnitude sample into
// 16-bit two's complement, buffers it in a one-entry holding register and
// shifts it MSB-first on both channels of a 32-bit-per-frame BCLK/LRCK stream.
module audio_dac_serializer #(
  parameter int BCLK_DIV = 4
) (
  input  logic        CLK,
  input  logic        resetN,
  input  logic        enable,
  input  logic [15:0] mag_in,
  input  logic        neg_in,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic        AUD_BCLK,
  output logic        AUD_DACLRCK,
  output logic        AUD_DACDAT,
  output logic        underrun
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [7:0] DIV_LAST = 8'(BCLK_DIV - 1);

  state_t      state_reg, state_next;
  logic [7:0]  div_reg, div_next;
  logic        bclk_reg, bclk_next;
  logic [4:0]  bit_cnt_reg, bit_cnt_next;
  logic        lrck_reg, lrck_next;
  logic        dat_reg, dat_next;
  logic        underrun_reg, underrun_next;
  logic [15:0] hold_reg, hold_next;
  logic        hold_full_reg, hold_full_next;
  logic [15:0] word_reg, word_next;

  logic [4:0]  bit_inc;
  logic [3:0]  bit_sel;

  // Saturating sign/magnitude to two's-complement conversion.
  function automatic logic [15:0] convert(input logic neg, input logic [15:0] mag);
    logic [15:0] res;
    if (!neg) begin
      res = mag[15] ? 16'h7FFF : mag;
    end else if (mag[15]) begin
      res = 16'h8000;
    end else begin
      res = ~mag + 16'd1;  // mag=0 wraps back to 0x0000
    end
    return res;
  endfunction

  // State register and all datapath registers; reset aborts any frame in flight.
  always_ff @(posedge CLK or negedge resetN) begin
    if (!resetN) begin
      state_reg     <= IDLE;
      div_reg       <= 8'd0;
      bclk_reg      <= 1'b0;
      bit_cnt_reg   <= 5'd31;
      lrck_reg      <= 1'b0;
      dat_reg       <= 1'b0;
      underrun_reg  <= 1'b0;
      hold_reg      <= 16'h0000;
      hold_full_reg <= 1'b0;
      word_reg      <= 16'h0000;
    end else begin
      state_reg     <= state_next;
      div_reg       <= div_next;
      bclk_reg      <= bclk_next;
      bit_cnt_reg   <= bit_cnt_next;
      lrck_reg      <= lrck_next;
      dat_reg       <= dat_next;
      underrun_reg  <= underrun_next;
      hold_reg      <= hold_next;
      hold_full_reg <= hold_full_next;
      word_reg      <= word_next;
    end
  end

  // Next-state logic: handshake, BCLK divider, bit sequencing and frame-start load.
  always_comb begin
    state_next     = state_reg;
    div_next       = div_reg;
    bclk_next      = bclk_reg;
    bit_cnt_next   = bit_cnt_reg;
    lrck_next      = lrck_reg;
    dat_next       = dat_reg;
    underrun_next  = 1'b0;
    hold_next      = hold_reg;
    hold_full_next = hold_full_reg;
    word_next      = word_reg;
    bit_inc        = bit_cnt_reg + 5'd1;
    bit_sel        = ~bit_inc[3:0];  // bit n carries word bit 15-(n mod 16)

    // The holding register accepts only while empty; a frame-start load can
    // never coincide with an accept because it requires the register full.
    if (sample_valid && !hold_full_reg) begin
      hold_next      = convert(neg_in, mag_in);
      hold_full_next = 1'b1;
    end

    case (state_reg)
      IDLE: begin
        div_next     = 8'd0;
        bclk_next    = 1'b0;
        bit_cnt_next = 5'd31;
        lrck_next    = 1'b0;
        dat_next     = 1'b0;
        if (enable) begin
          state_next = RUN;
        end
      end

      RUN: begin
        if (div_reg == DIV_LAST) begin
          div_next  = 8'd0;
          bclk_next = ~bclk_reg;
          if (bclk_reg) begin
            // BCLK falling: advance to the next bit and present its data.
            if (bit_inc == 5'd0 && !enable) begin
              state_next   = IDLE;
              bclk_next    = 1'b0;
              bit_cnt_next = 5'd31;
              lrck_next    = 1'b0;
              dat_next     = 1'b0;
            end else begin
              bit_cnt_next = bit_inc;
              if (bit_inc == 5'd0) begin
                lrck_next = 1'b1;
                if (hold_full_reg) begin
                  word_next      = hold_reg;
                  hold_full_next = 1'b0;
                  dat_next       = hold_reg[15];
                end else begin
                  underrun_next = 1'b1;
                  dat_next      = word_reg[15];
                end
              end else begin
                if (bit_inc == 5'd16) begin
                  lrck_next = 1'b0;
                end
                dat_next = word_reg[bit_sel];
              end
            end
          end
        end else begin
          div_next = div_reg + 8'd1;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign sample_ready = ~hold_full_reg;
  assign AUD_BCLK     = bclk_reg;
  assign AUD_DACLRCK  = lrck_reg;
  assign AUD_DACDAT   = dat_reg;
  assign underrun     = underrun_reg;

endmodule

// File: tb/tb_audio_dac_serializer.sv
// Directed bench for audio_dac_serializer with BCLK_DIV=2 (BCLK period 4 CLK,
// 128 CLK per frame). Sampling and driving happen on the falling CLK edge.
module tb_audio_dac_serializer;

  localparam int DIV = 2;

  logic        CLK = 1'b0;
  logic        resetN = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] mag_in = 16'h0000;
  logic        neg_in = 1'b0;
  logic        sample_valid = 1'b0;
  logic        sample_ready;
  logic        AUD_BCLK;
  logic        AUD_DACLRCK;
  logic        AUD_DACDAT;
  logic        underrun;

  int checks = 0;
  int errors = 0;
  int ur_count = 0;
  int acc_count = 0;

  audio_dac_serializer #(.BCLK_DIV(DIV)) dut (
    .CLK(CLK),
    .resetN(resetN),
    .enable(enable),
    .mag_in(mag_in),
    .neg_in(neg_in),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .AUD_BCLK(AUD_BCLK),
    .AUD_DACLRCK(AUD_DACLRCK),
    .AUD_DACDAT(AUD_DACDAT),
    .underrun(underrun)
  );

  always #5 CLK = ~CLK;

  // Count underrun pulses and accepted handshakes at each active edge.
  always @(posedge CLK) begin
    if (underrun === 1'b1) ur_count++;
    if (sample_valid && sample_ready === 1'b1) acc_count++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One-cycle valid pulse; the holding register must be empty beforehand.
  task automatic push(input logic neg, input logic [15:0] mag);
    check("push_ready", {31'd0, sample_ready}, 32'd1);
    neg_in = neg;
    mag_in = mag;
    sample_valid = 1'b1;
    tick(1);
    sample_valid = 1'b0;
    check("push_taken", {31'd0, sample_ready}, 32'd0);
  endtask

  // From the bit-31 sample point: push, then land on the next bit-0 point.
  task automatic push_align(input logic neg, input logic [15:0] mag);
    push(neg, mag);
    tick(3);
  endtask

  task automatic wait_frame(input int exp_lat);
    int n = 0;
    while (AUD_DACLRCK !== 1'b1 && n < 40) begin
      tick(1);
      n++;
    end
    check("frame_latency", n, exp_lat);
  endtask

  // Called at the bit-0 sample point; returns at the bit-31 sample point.
  task automatic capture(input string tag, input logic [15:0] w);
    logic [31:0] bits;
    bits = 32'd0;
    bits[31] = AUD_DACDAT;
    check("lrck_start", {31'd0, AUD_DACLRCK}, 32'd1);
    check("bclk_low", {31'd0, AUD_BCLK}, 32'd0);
    tick(2);
    check("bclk_high", {31'd0, AUD_BCLK}, 32'd1);
    tick(2);
    for (int n = 1; n < 32; n++) begin
      bits[31-n] = AUD_DACDAT;
      if (n == 15) check("lrck_bit15", {31'd0, AUD_DACLRCK}, 32'd1);
      if (n == 16) check("lrck_bit16", {31'd0, AUD_DACLRCK}, 32'd0);
      if (n < 31) tick(4);
    end
    check(tag, bits, {w, w});
    $display("frame %s: bits=%h expected=%h", tag, bits, {w, w});
  endtask

  logic        negs [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [15:0] mags [5] = '{16'h1234, 16'h0001, 16'h9000, 16'hFFFF, 16'h0000};
  logic [15:0] exps [5] = '{16'h1234, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h0000};

  initial begin
    int a0;

    // Reset state
    tick(3);
    check("rst_bclk", {31'd0, AUD_BCLK}, 32'd0);
    check("rst_lrck", {31'd0, AUD_DACLRCK}, 32'd0);
    check("rst_dat", {31'd0, AUD_DACDAT}, 32'd0);
    check("rst_ready", {31'd0, sample_ready}, 32'd1);
    check("rst_underrun", {31'd0, underrun}, 32'd0);
    resetN = 1'b1;
    tick(4);
    check("idle_bclk", {31'd0, AUD_BCLK}, 32'd0);

    // Handshake in IDLE; a second valid while full must be ignored
    push(negs[0], mags[0]);
    neg_in = 1'b0;
    mag_in = 16'hAAAA;
    sample_valid = 1'b1;
    tick(1);
    sample_valid = 1'b0;
    check("ignored_ready", {31'd0, sample_ready}, 32'd0);

    enable = 1'b1;
    wait_frame(5);

    // Conversion table, one sample per frame
    for (int i = 0; i < 5; i++) begin
      capture("conv", exps[i]);
      if (i < 4) push_align(negs[i+1], mags[i+1]);
      else push_align(1'b1, 16'h7FFF);  // converts to 0x8001
    end
    capture("pattern_8001", 16'h8001);
    check("no_underrun", ur_count, 0);

    // Underrun: one sample, then starvation repeats it
    push_align(1'b0, 16'h00FF);
    capture("word_00ff", 16'h00FF);
    tick(4);
    capture("repeat1_00ff", 16'h00FF);
    check("underrun_cnt1", ur_count, 1);
    tick(4);
    capture("repeat2_00ff", 16'h00FF);
    check("underrun_cnt2", ur_count, 2);

    // Continuous valid: one accept per frame
    a0 = acc_count;
    neg_in = 1'b0;
    mag_in = 16'h4321;
    sample_valid = 1'b1;
    tick(4);
    check("hs_ready_after_load", {31'd0, sample_ready}, 32'd1);
    capture("hs_frame1", 16'h4321);
    check("hs_ready_held", {31'd0, sample_ready}, 32'd0);
    check("hs_accepts1", acc_count - a0, 2);
    tick(4);
    check("hs_ready_after_load2", {31'd0, sample_ready}, 32'd1);
    capture("hs_frame2", 16'h4321);
    check("hs_accepts2", acc_count - a0, 3);
    sample_valid = 1'b0;
    check("hs_no_underrun", ur_count, 2);

    // Stop at bit 5: frame completes, then outputs idle
    tick(4);
    tick(20);
    enable = 1'b0;
    tick(104);
    check("stop_bit31_lrck", {31'd0, AUD_DACLRCK}, 32'd0);
    check("stop_bit31_dat", {31'd0, AUD_DACDAT}, 32'd1);
    tick(4);
    check("stop_bclk", {31'd0, AUD_BCLK}, 32'd0);
    check("stop_lrck", {31'd0, AUD_DACLRCK}, 32'd0);
    check("stop_dat", {31'd0, AUD_DACDAT}, 32'd0);
    tick(2);
    check("stop_bclk_held", {31'd0, AUD_BCLK}, 32'd0);
    check("stop_no_underrun", ur_count, 2);

    // Restart
    push(1'b0, 16'h0F0F);
    enable = 1'b1;
    wait_frame(5);
    capture("restart", 16'h0F0F);

    // Reset mid-frame at bit 20 with the holding register full
    push_align(1'b0, 16'h0800);
    push(1'b0, 16'h5555);
    tick(81);
    check("pre_reset_bclk", {31'd0, AUD_BCLK}, 32'd1);
    check("pre_reset_dat", {31'd0, AUD_DACDAT}, 32'd1);
    resetN = 1'b0;
    #1;
    check("async_bclk", {31'd0, AUD_BCLK}, 32'd0);
    check("async_lrck", {31'd0, AUD_DACLRCK}, 32'd0);
    check("async_dat", {31'd0, AUD_DACDAT}, 32'd0);
    check("async_ready", {31'd0, sample_ready}, 32'd1);
    check("async_underrun", {31'd0, underrun}, 32'd0);
    tick(2);
    resetN = 1'b1;
    wait_frame(5);
    capture("post_reset", 16'h0000);
    check("post_reset_underrun", ur_count, 3);

    enable = 1'b0;
    tick(4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/audio_dac_serializer.md
AUDIO_DAC_SERIALIZER -- requirements
Module: audio_dac_serializer

Interface
REQ-001 Parameter BCLK_DIV, default 4: number of CLK cycles per BCLK half-period; legal range 2..255.
REQ-002 CLK  input  1  system clock; all state changes on its rising edge.
REQ-003 resetN  input  1  asynchronous, active-low reset.
REQ-004 enable  input  1  level; high = run the serial stream, low = stop at the next frame boundary.
REQ-005 mag_in  input  16  unsigned sample magnitude.
REQ-006 neg_in  input  1  sample sign; 1 = negative.
REQ-007 sample_valid  input  1  mag_in/neg_in are valid this cycle.
REQ-008 sample_ready  output  1  the holding register is empty and can accept a sample.
REQ-009 AUD_BCLK  output  1  bit clock to the codec.
REQ-010 AUD_DACLRCK  output  1  channel clock; 1 = left, 0 = right.
REQ-011 AUD_DACDAT  output  1  serial two's-complement data, MSB first.
REQ-012 underrun  output  1  one-CLK pulse when a frame starts with an empty holding register.

Function
REQ-013 Conversion (combinational, on accept) SHALL map (neg_in, mag_in) to a 16-bit signed value:
- neg=0, mag<=0x7FFF -> mag.
- neg=0, mag>0x7FFF -> 0x7FFF (saturate).
- neg=1, mag>=0x8000 -> 0x8000.
- neg=1, otherwise -> (~mag)+1.
- neg=1 with mag=0 -> 0x0000.
REQ-014 Handshake: a sample SHALL be accepted when sample_valid && sample_ready; the converted value is stored in the holding register and sample_ready goes low the next cycle.
REQ-015 sample_valid while sample_ready=0 SHALL be ignored, with no change to the holding register.
REQ-016 States: IDLE and RUN.
- IDLE -> RUN when enable=1, with the bit counter preset to 31 and the divider at 0.
- RUN -> IDLE at the first frame boundary (bit counter 31->0 transition) where enable=0.
REQ-017 In IDLE, AUD_BCLK, AUD_DACLRCK and AUD_DACDAT SHALL be held at 0; the handshake remains operational.
REQ-018 Divider (RUN): counts 0..BCLK_DIV-1 and wraps; at terminal count AUD_BCLK toggles.
- BCLK period = 2*BCLK_DIV CLK cycles.
- Frame length = 64*BCLK_DIV CLK cycles.
REQ-019 On each BCLK falling toggle, the 5-bit bit counter SHALL advance modulo 32 and AUD_DACDAT SHALL update in the same cycle; data is stable across the BCLK rising edge.
REQ-020 Frame start (bit counter becomes 0) SHALL perform all of the following in one CLK:
- set AUD_DACLRCK=1;
- load the holding register, if full, into both the left and the right shift word;
- mark the holding register empty, so sample_ready=1 the next cycle.
REQ-021 Channel timing: AUD_DACLRCK SHALL go 0 when the bit counter becomes 16. The format is left-justified: the MSB is driven in the same cycle as each LRCK edge.
REQ-022 Bit mapping: the same 16-bit word is sent on both channels (mono). Bit counter n drives bit 15-(n mod 16).
REQ-023 Underrun: if the holding register is empty at frame start, the previous word SHALL be repeated and underrun pulses for that one CLK. The word after reset is 0x0000.
REQ-024 Simultaneous accept and frame-start load cannot occur because sample_ready is low while the holding register is full; no other priority rule is needed.
REQ-025 enable deasserted mid-frame SHALL complete the current 32-bit frame before entering IDLE. Re-asserting enable before the boundary continues RUN seamlessly.

Reset
REQ-026 resetN=0 SHALL immediately force all of the following:
- state=IDLE;
- AUD_BCLK=0, AUD_DACLRCK=0, AUD_DACDAT=0;
- sample_ready=1, underrun=0;
- holding register empty;
- divider=0, bit counter=31;
- last word=0x0000.
REQ-027 Reset asserted mid-frame SHALL abort the frame without completing it; a sample held in the holding register is discarded.

Verification (BCLK_DIV=2)
REQ-028 Conversion: accept (neg=0,0x1234), (neg=1,0x0001), (neg=1,0x9000), (neg=0,0xFFFF), (neg=1,0x0000) -> shifted words 0x1234, 0xFFFF, 0x8000, 0x7FFF, 0x0000.
REQ-029 Timing: enable=1 with 0x8001 preloaded -> BCLK period 4 CLK; LRCK high for 64 CLK then low for 64 CLK; DACDAT=1 on the first and 17th BCLK falling edges of the frame, 0 on bits 1-14, 1 on bits 15 and 31.
REQ-030 Underrun: send one sample 0x00FF, then none -> the next frame repeats 0x00FF on both channels and underrun pulses exactly once per starved frame.
REQ-031 Handshake: hold sample_valid=1 continuously -> exactly one accept per frame; sample_ready low from the accept until the cycle after the frame-start load.
REQ-032 Stop/restart: drop enable at bit 5 -> the frame finishes through bit 31, then outputs return to 0. Re-enabling starts a new frame with LRCK rising at the first BCLK falling edge.
REQ-033 Reset: assert resetN=0 at bit 20 with the holding register full -> all outputs reach reset values asynchronously, sample_ready=1, and the next frame after release sends 0x0000.
